wb_dmem_arbiter: RTL and testbench
==================================

WB_DMEM_ARBITER -- requirements
Module: wb_dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width; byte-select width DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, stalled-strobe limit; legal values >= 2.
REQ-004 clk_i  input  1  single system clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 mN_cyc_i / mN_stb_i / mN_we_i  input  1 each  Wishbone B4 master N controls (N=0,1; m0 = CPU data port, m1 = DMA/debug).
REQ-007 mN_adr_i  input  ADDR_WIDTH  master N address.
REQ-008 mN_dat_i  input  DATA_WIDTH  master N write data.
REQ-009 mN_sel_i  input  DATA_WIDTH/8  master N byte select.
REQ-010 mN_ack_o / mN_err_o  output  1 each  master N acknowledge / error.
REQ-011 mN_dat_o  output  DATA_WIDTH  master N read data.
REQ-012 s_cyc_o / s_stb_o / s_we_o  output  1 each  controls to data memory slave.
REQ-013 s_adr_o / s_dat_o / s_sel_o  output  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  slave address, write data, byte select.
REQ-014 s_ack_i / s_err_i  input  1 each  slave acknowledge / error.
REQ-015 s_dat_i  input  DATA_WIDTH  slave read data.
REQ-016 grant_o  output  2  one-hot current owner (bit N = master N), 2'b00 when idle.
REQ-017 timeout_o  output  1  single-cycle pulse when a timeout error is generated.

Function
REQ-018 FSM states IDLE, OWN0, OWN1; plus registers last_owner (1 bit) and timeout counter ($clog2(TIMEOUT_CYCLES)+1 bits).
REQ-019 IDLE: all s_* outputs 0, all mN_ack_o/mN_err_o/mN_dat_o 0, grant_o 2'b00.
REQ-020 IDLE with exactly one mN_cyc_i high -> OWNN next edge (one-cycle arbitration latency).
REQ-021 IDLE with both cyc high -> own the master != last_owner (round-robin); last_owner resets to 1 so m0 wins first contention.
REQ-022 OWNN: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o combinationally equal master N inputs.
REQ-023 OWNN: mN_ack_o = s_ack_i, mN_dat_o = s_dat_i, mN_err_o = s_err_i | timeout_err; non-owner sees ack, err, dat all 0.
REQ-024 Ownership held for entire cycle (any number of strobes) while mN_cyc_i high; other master's request never preempts.
REQ-025 OWNN with mN_cyc_i low -> IDLE next edge, last_owner <= N; minimum one IDLE cycle between owners.
REQ-026 Timeout counter clears on s_ack_i, s_err_i, s_stb_o low, or any state change; else increments each OWN cycle.
REQ-027 Counter == TIMEOUT_CYCLES-1 with stb high and no ack/err: timeout_err = 1 that cycle, s_stb_o forced 0 that cycle, timeout_o = 1, counter clears.
REQ-028 s_ack_i and s_err_i both high: forwarded to owner unmodified; s_ack_i/s_err_i ignored in IDLE.
REQ-029 Write data/strobes never reach the slave unless owner's stb is high in an OWN state.

Reset
REQ-030 rst_ni low at a rising edge: state <= IDLE, last_owner <= 1, counter <= 0, regardless of current state or in-flight transfer.
REQ-031 Resulting outputs: all s_*, mN_ack_o, mN_err_o, mN_dat_o, grant_o, timeout_o = 0 from that edge until a new grant.

Verification
REQ-032 m0 read adr 0x10, slave acks dat 0xDEADBEEF combinationally -> cycle 1 grant_o=01, s_adr_o=0x10, m0_ack_o=1, m0_dat_o=0xDEADBEEF, m1_ack_o=0.
REQ-033 Both cyc high out of reset -> m0 owns first; after m0 drops cyc, IDLE one cycle, then m1 owns; next contention m0 again.
REQ-034 m1 holds cyc for 3 writes sel=4'b0011 while m0 requests -> m0_ack_o stays 0, s_sel_o=0011 each stb, m0 granted 2 cycles after m1 drops cyc.
REQ-035 Slave never acks, TIMEOUT_CYCLES=16, m0 stb held -> on 16th OWN0 stb cycle m0_err_o=1, timeout_o=1, s_stb_o=0; next cycle counter restarts.
REQ-036 rst_ni low for one edge during OWN1 mid-write -> next cycle grant_o=00, s_cyc_o=0, no slave write; later simultaneous request grants m0.
REQ-037 s_err_i=1 during OWN1 -> m1_err_o=1, m0_err_o=0, timeout_o=0.

Source files
------------

// File: rtl/wb_dmem_arbiter.sv
// Two-master Wishbone B4 arbiter in front of a single data-memory slave.
// Round-robin on contention, ownership held for the whole bus cycle, stalled-strobe timeout.
module wb_dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e           state_q;
    logic             last_owner_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;
    logic [SEL_W-1:0]      own_sel;
    logic                  is_own0;
    logic                  is_own1;
    logic                  timeout_err;
    logic                  stb_out;

    // Select the current owner's request; everything reads as zero while idle.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        case (state_q)
            OWN0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_sel = m0_sel_i;
            end
            OWN1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_sel = m1_sel_i;
            end
            default: ;
        endcase
    end

    assign is_own0 = (state_q == OWN0);
    assign is_own1 = (state_q == OWN1);

    // A strobe stalled for TIMEOUT_CYCLES cycles is terminated with an error instead of the slave.
    assign timeout_err = (is_own0 || is_own1) && own_stb && !s_ack_i && !s_err_i
                         && (tmo_cnt_q == CNT_LIMIT);
    assign stb_out     = own_stb && !timeout_err;

    assign s_cyc_o   = own_cyc;
    assign s_stb_o   = stb_out;
    assign s_we_o    = own_we;
    assign s_adr_o   = own_adr;
    assign s_dat_o   = own_dat;
    assign s_sel_o   = own_sel;

    assign m0_ack_o  = is_own0 && s_ack_i;
    assign m0_err_o  = is_own0 && (s_err_i || timeout_err);
    assign m0_dat_o  = is_own0 ? s_dat_i : '0;
    assign m1_ack_o  = is_own1 && s_ack_i;
    assign m1_err_o  = is_own1 && (s_err_i || timeout_err);
    assign m1_dat_o  = is_own1 ? s_dat_i : '0;

    assign grant_o   = {is_own1, is_own0};
    assign timeout_o = timeout_err;

    // Arbitration state, round-robin history and stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            tmo_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_cnt_q <= '0;
                    if (m0_cyc_i && m1_cyc_i) begin
                        state_q <= last_owner_q ? OWN0 : OWN1;
                    end else if (m0_cyc_i) begin
                        state_q <= OWN0;
                    end else if (m1_cyc_i) begin
                        state_q <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc) begin
                        state_q      <= IDLE;
                        last_owner_q <= is_own1;
                        tmo_cnt_q    <= '0;
                    end else if (s_ack_i || s_err_i || !stb_out) begin
                        tmo_cnt_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    tmo_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dmem_arbiter.sv
// Self-checking bench for wb_dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural bus-ownership model.
module tb_wb_dmem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_dat, m1_dat;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic          s_ack, s_err;
    logic [DW-1:0] s_rdat;
    logic [1:0]    grant;
    logic          tmo_pulse;

    always #5 clk = ~clk;

    wb_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_ack_i(s_ack), .s_err_i(s_err),
        .s_dat_i(s_rdat),
        .grant_o(grant), .timeout_o(tmo_pulse)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: who holds the bus (-1 none), who held it last, how long the strobe has stalled.
    int owner = -1;
    int last  = 1;
    int stall = 0;

    logic          e_cyc, e_stb, e_we, e_tmo;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic          e_m0_ack, e_m0_err, e_m1_ack, e_m1_err;
    logic [DW-1:0] e_m0_dat, e_m1_dat;
    logic [1:0]    e_grant;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compute();
        logic ostb;
        e_cyc = 1'b0; e_we = 1'b0; ostb = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        if (owner == 0) begin
            e_cyc = m0_cyc; ostb = m0_stb; e_we = m0_we; e_adr = m0_adr; e_dat = m0_dat; e_sel = m0_sel;
        end else if (owner == 1) begin
            e_cyc = m1_cyc; ostb = m1_stb; e_we = m1_we; e_adr = m1_adr; e_dat = m1_dat; e_sel = m1_sel;
        end
        e_tmo    = (owner >= 0) && ostb && !s_ack && !s_err && (stall == TMO - 1);
        e_stb    = ostb && !e_tmo;
        e_m0_ack = (owner == 0) && s_ack;
        e_m1_ack = (owner == 1) && s_ack;
        e_m0_err = (owner == 0) && (s_err || e_tmo);
        e_m1_err = (owner == 1) && (s_err || e_tmo);
        e_m0_dat = (owner == 0) ? s_rdat : '0;
        e_m1_dat = (owner == 1) ? s_rdat : '0;
        e_grant  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    endtask

    // Mid-cycle: every output against the model.
    task automatic eval();
        #4;
        compute();
        chk("s_cyc", 64'(s_cyc), 64'(e_cyc));
        chk("s_stb", 64'(s_stb), 64'(e_stb));
        chk("s_we", 64'(s_we), 64'(e_we));
        chk("s_adr", 64'(s_adr), 64'(e_adr));
        chk("s_dat", 64'(s_wdat), 64'(e_dat));
        chk("s_sel", 64'(s_sel), 64'(e_sel));
        chk("m0_ack", 64'(m0_ack), 64'(e_m0_ack));
        chk("m0_err", 64'(m0_err), 64'(e_m0_err));
        chk("m0_dat", 64'(m0_rdat), 64'(e_m0_dat));
        chk("m1_ack", 64'(m1_ack), 64'(e_m1_ack));
        chk("m1_err", 64'(m1_err), 64'(e_m1_err));
        chk("m1_dat", 64'(m1_rdat), 64'(e_m1_dat));
        chk("grant", 64'(grant), 64'(e_grant));
        chk("timeout", 64'(tmo_pulse), 64'(e_tmo));
    endtask

    // Advance the model across the rising edge using the inputs held during this cycle.
    task automatic tick();
        logic c0, c1, stalled;
        compute();
        c0 = m0_cyc; c1 = m1_cyc;
        stalled = e_stb && !s_ack && !s_err;
        @(posedge clk);
        if (!rst_ni) begin
            owner = -1; last = 1; stall = 0;
        end else if (owner < 0) begin
            stall = 0;
            if (c0 && c1) owner = 1 - last;
            else if (c0)  owner = 0;
            else if (c1)  owner = 1;
        end else if (!e_cyc) begin
            last = owner; owner = -1; stall = 0;
        end else begin
            stall = stalled ? stall + 1 : 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
        s_ack = 0; s_err = 0; s_rdat = '0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        tick();
        rst_ni = 1;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 0;
        tick();
        tick();
        rst_ni = 1;
        eval();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_s_cyc", 64'(s_cyc), 64'h0);

        // Single m0 read, slave answers in the same cycle.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10; s_ack = 1; s_rdat = 32'hDEADBEEF;
        eval(); tick();
        eval();
        chk("rd_grant", 64'(grant), 64'h1);
        chk("rd_adr", 64'(s_adr), 64'h10);
        chk("rd_ack", 64'(m0_ack), 64'h1);
        chk("rd_dat", 64'(m0_rdat), 64'hDEADBEEF);
        chk("rd_m1_ack", 64'(m1_ack), 64'h0);
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        tick();

        // Contention out of reset: m0, then m1 after an idle cycle, then m0 again.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        eval(); tick();
        eval(); chk("rr_first", 64'(grant), 64'h1);
        m0_cyc = 0; m0_stb = 0;
        eval(); tick();
        eval(); chk("rr_gap", 64'(grant), 64'h0);
        tick();
        eval(); chk("rr_second", 64'(grant), 64'h2);
        m1_cyc = 0; m1_stb = 0;
        eval(); tick();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        eval(); tick();
        eval(); chk("rr_third", 64'(grant), 64'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        eval(); tick();

        // m1 burst of three writes while m0 waits.
        m1_cyc = 1; m1_we = 1; m1_sel = 4'b0011; m0_cyc = 1; m0_stb = 1;
        eval(); tick();
        eval(); chk("burst_grant", 64'(grant), 64'h2);
        for (int i = 0; i < 3; i++) begin
            m1_stb = 1; m1_adr = 32'(i * 4); m1_dat = $urandom;
            eval();
            chk("burst_sel", 64'(s_sel), 64'h3);
            chk("burst_m0_ack", 64'(m0_ack), 64'h0);
            tick();
        end
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        eval(); tick();
        eval(); tick();
        eval(); chk("burst_m0_wait", 64'(grant), 64'h1);
        m0_cyc = 0; m0_stb = 0;
        eval(); tick();

        // Silent slave: timeout on the 16th stalled strobe cycle, then counting restarts.
        do_reset();
        m0_cyc = 1; m0_stb = 1; s_ack = 0; s_err = 0;
        eval(); tick();
        for (int k = 1; k <= TMO + 1; k++) begin
            eval();
            if (k == TMO) begin
                chk("tmo_err", 64'(m0_err), 64'h1);
                chk("tmo_pulse", 64'(tmo_pulse), 64'h1);
                chk("tmo_stb", 64'(s_stb), 64'h0);
            end else begin
                chk("tmo_quiet", 64'(tmo_pulse), 64'h0);
                chk("tmo_stb_on", 64'(s_stb), 64'h1);
            end
            tick();
        end
        m0_cyc = 0; m0_stb = 0;
        eval(); tick();

        // Reset in the middle of an m1 write.
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h40; m1_dat = 32'h1234;
        eval(); tick();
        eval(); chk("mid_we", 64'(s_we), 64'h1);
        rst_ni = 0;
        tick();
        rst_ni = 1;
        m0_cyc = 1; m0_stb = 1;
        eval();
        chk("mid_grant", 64'(grant), 64'h0);
        chk("mid_cyc", 64'(s_cyc), 64'h0);
        chk("mid_stb", 64'(s_stb), 64'h0);
        tick();
        eval(); chk("mid_regrant", 64'(grant), 64'h1);

        // Slave error toward m1.
        m0_cyc = 0; m0_stb = 0;
        eval(); tick();
        eval(); tick();
        s_err = 1;
        eval();
        chk("err_m1", 64'(m1_err), 64'h1);
        chk("err_m0", 64'(m0_err), 64'h0);
        chk("err_tmo", 64'(tmo_pulse), 64'h0);
        tick();
        idle_inputs();
        eval(); tick();

        // Randomized traffic; slave alternates between responsive and silent phases.
        begin
            int quiet = 0;
            for (int n = 0; n < 4000; n++) begin
                if (n % 150 == 0) quiet = ($urandom_range(0, 2) == 0);
                rst_ni = ($urandom_range(0, 299) != 0);
                if (m0_cyc) m0_cyc = ($urandom_range(0, 7) != 0);
                else        m0_cyc = ($urandom_range(0, 3) == 0);
                if (m1_cyc) m1_cyc = ($urandom_range(0, 7) != 0);
                else        m1_cyc = ($urandom_range(0, 3) == 0);
                m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
                m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
                m0_we = 1'($urandom); m1_we = 1'($urandom);
                m0_adr = $urandom; m1_adr = $urandom;
                m0_dat = $urandom; m1_dat = $urandom;
                m0_sel = 4'($urandom); m1_sel = 4'($urandom);
                s_rdat = $urandom;
                s_ack = !quiet && ($urandom_range(0, 2) == 0);
                s_err = !quiet && ($urandom_range(0, 15) == 0);
                eval();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
